// File: rtl/add10_arbiter_pkg.sv
// add10_arb_pkg: shared types and limits for the add10_arbiter slice.
// Optional feature macro ADD10_ARB_COUT_EN (see add10_arbiter.sv).
package add10_arb_pkg;
  localparam int ADD_W   = 10;
  localparam int MAX_REQ = 8;

  typedef logic [ADD_W-1:0] add_opnd_t;

  // Carry out of the MSB recovered from operand and sum MSBs only.
  function automatic logic carry_out(add_opnd_t a, add_opnd_t b, add_opnd_t s);
    return (a[ADD_W-1] & b[ADD_W-1]) | ((a[ADD_W-1] ^ b[ADD_W-1]) & ~s[ADD_W-1]);
  endfunction
endpackage

// File: rtl/add10_arbiter_if.sv
// add10_arbiter_if: requester-side and result-side handshake bundle.
// rsp_cout_o exists only when ADD10_ARB_COUT_EN is defined.
interface add10_arbiter_if #(parameter int NUM_REQ = 4);
  import add10_arb_pkg::*;
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  add_opnd_t [NUM_REQ-1:0]       req_a_i;
  add_opnd_t [NUM_REQ-1:0]       req_b_i;
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  add_opnd_t                     rsp_sum_o;
  logic [ID_W-1:0]               rsp_id_o;
`ifdef ADD10_ARB_COUT_EN
  logic                          rsp_cout_o;

  modport slave  (input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
                  output req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o, rsp_cout_o);
  modport master (output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
                  input  req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o, rsp_cout_o);
`else
  modport slave  (input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
                  output req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o);
  modport master (output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
                  input  req_ready_o, rsp_valid_o, rsp_sum_o, rsp_id_o);
`endif
endinterface

// File: rtl/add10_rr_pick.sv
// add10_rr_pick: combinational circular priority picker. The first set
// request at or after ptr_i (wrapping) wins.
module add10_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);
  int j;

  // Walk NUM_REQ slots starting at ptr; first hit is the winner.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/adder_10bit.sv
// adder_10bit: shared unsigned 10-bit adder, sum wraps mod 1024.
module adder_10bit
  import add10_arb_pkg::*;
(
  input  add_opnd_t a_i,
  input  add_opnd_t b_i,
  output add_opnd_t s_o
);
  assign s_o = a_i + b_i;
endmodule

// File: rtl/add10_arbiter.sv
// add10_arbiter: round-robin share of one adder_10bit among NUM_REQ
// requesters with a one-entry registered result.
// Macro ADD10_ARB_COUT_EN adds a registered carry-out on rsp_cout_o.
module add10_arbiter
  import add10_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  add10_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_cfg
    $error("add10_arbiter: NUM_REQ out of range");
  end

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win_idx;
  logic               any_req;
  logic               slot_free;
  logic               xfer;
  add_opnd_t          opnd_a, opnd_b, sum;

  logic               valid_q, valid_d;
  add_opnd_t          sum_q, sum_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  add10_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (bus.req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  // Result slot can take a new sum if empty or draining this edge.
  assign slot_free       = !valid_q || bus.rsp_ready_i;
  assign xfer            = rst_ni && slot_free && any_req;
  assign bus.req_ready_o = (rst_ni && slot_free) ? gnt : '0;

  assign opnd_a = bus.req_a_i[win_idx];
  assign opnd_b = bus.req_b_i[win_idx];

  adder_10bit u_add (
    .a_i (opnd_a),
    .b_i (opnd_b),
    .s_o (sum)
  );

  // Next state: load on transfer, clear valid on pure drain, else hold.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      sum_d   = sum;
      id_d    = win_idx;
      ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (valid_q && bus.rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Result register and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.rsp_valid_o = valid_q;
  assign bus.rsp_sum_o   = sum_q;
  assign bus.rsp_id_o    = id_q;

`ifdef ADD10_ARB_COUT_EN
  logic cout_q, cout_d;

  // Carry is captured with the sum and held with it.
  always_comb begin
    cout_d = cout_q;
    if (xfer) cout_d = carry_out(opnd_a, opnd_b, sum);
  end

  // Carry register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cout_q <= 1'b0;
    else         cout_q <= cout_d;
  end

  assign bus.rsp_cout_o = cout_q;
`endif
endmodule

// File: tb/tb_add10_arbiter.sv
// tb_add10_arbiter: directed table, hand sequences, and randomized traffic
// against a queue-based round-robin reference model.
module tb_add10_arbiter;
  import add10_arb_pkg::*;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add10_arbiter_if #(.NUM_REQ(N)) bus ();
  add10_arbiter #(.NUM_REQ(N)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  int dut_cout;
  always_comb begin
`ifdef ADD10_ARB_COUT_EN
    dut_cout = int'(bus.rsp_cout_o);
`else
    dut_cout = 0;
`endif
  end

  // Reference model: priority order kept as a rotating queue of ids.
  int m_valid, m_sum, m_id, m_cout;
  int order[$];

  task automatic model_reset();
    m_valid = 0; m_sum = 0; m_id = 0; m_cout = 0;
    order = {};
    for (int i = 0; i < N; i++) order.push_back(i);
  endtask

  task automatic check_rsp(input string tag);
    chk({tag, ".valid"}, int'(bus.rsp_valid_o), m_valid);
    chk({tag, ".sum"},   int'(bus.rsp_sum_o),   m_sum);
    chk({tag, ".id"},    int'(bus.rsp_id_o),    m_id);
`ifdef ADD10_ARB_COUT_EN
    chk({tag, ".cout"},  dut_cout,              m_cout);
`endif
  endtask

  // One cycle: inputs already driven; compare, advance model, clock.
  task automatic step(output int granted);
    int w, s, exp_rdy;
    bit free;
    #1;
    check_rsp("pre");
    free = (m_valid == 0) || bus.rsp_ready_i;
    w = -1;
    foreach (order[k]) if (w < 0 && bus.req_valid_i[order[k]]) w = order[k];
    exp_rdy = (free && w >= 0) ? (1 << w) : 0;
    chk("ready", int'(bus.req_ready_o), exp_rdy);
    granted = -1;
    if (free && w >= 0) begin
      s = int'(bus.req_a_i[w]) + int'(bus.req_b_i[w]);
      m_valid = 1; m_sum = s % 1024; m_id = w; m_cout = (s >= 1024) ? 1 : 0;
      while (order[0] != w) order.push_back(order.pop_front());
      order.push_back(order.pop_front());
      granted = w;
    end else if (m_valid != 0 && bus.rsp_ready_i) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid_i = '1;
    bus.rsp_ready_i = 1'b1;
    #1;
    chk("rst.ready", int'(bus.req_ready_o), 0);
    chk("rst.valid", int'(bus.rsp_valid_o), 0);
    chk("rst.sum",   int'(bus.rsp_sum_o),   0);
    chk("rst.id",    int'(bus.rsp_id_o),    0);
    chk("rst.cout",  dut_cout,              0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid_i = '0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] vld;
    int           a, b;
    logic         rrdy;
    int           rdy;    // expected ready before the edge
    int           valid;  // expected after the edge
    int           sum;
    int           id;
    int           cout;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [N-1:0] vld, input int a, input int b, input logic rrdy,
                         input int rdy, input int valid, input int sum, input int id, input int cout);
    vec_t v;
    v.vld = vld; v.a = a; v.b = b; v.rrdy = rrdy; v.rdy = rdy;
    v.valid = valid; v.sum = sum; v.id = id; v.cout = cout;
    tbl.push_back(v);
  endtask

  // Randomized requesters honouring the hold-until-ready rule.
  bit [N-1:0]  pend;
  add_opnd_t   ra[N], rb[N];

  initial begin
    int g;
    bus.req_valid_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.rsp_ready_i = 1'b1;
    model_reset();

    add_vec(4'b0100, 'h123, 'h0FF, 1, 'b0100, 1, 'h222, 2, 0);
    add_vec(4'b1111, 'h001, 'h002, 1, 'b1000, 1, 'h003, 3, 0);
    add_vec(4'b1111, 'h010, 'h020, 1, 'b0001, 1, 'h030, 0, 0);
    add_vec(4'b1111, 'h3FF, 'h001, 1, 'b0010, 1, 'h000, 1, 1);
    add_vec(4'b1111, 'h200, 'h200, 1, 'b0100, 1, 'h000, 2, 1);
    add_vec(4'b1111, 'h0AA, 'h055, 1, 'b1000, 1, 'h0FF, 3, 0);
    add_vec(4'b1111, 'h001, 'h001, 1, 'b0001, 1, 'h002, 0, 0);
    for (int i = 0; i < 5; i++)
      add_vec(4'b0010, 'h005, 'h006, 0, 'b0000, 1, 'h002, 0, 0);
    add_vec(4'b0010, 'h005, 'h006, 1, 'b0010, 1, 'h00B, 1, 0);
    add_vec(4'b0000, 'h000, 'h000, 1, 'b0000, 0, 'h00B, 1, 0);
    add_vec(4'b0000, 'h000, 'h000, 0, 'b0000, 0, 'h00B, 1, 0);
    add_vec(4'b1001, 'h007, 'h001, 1, 'b1000, 1, 'h008, 3, 0);
    add_vec(4'b1001, 'h007, 'h001, 1, 'b0001, 1, 'h008, 0, 0);

    do_reset();
    foreach (tbl[i]) begin
      bus.req_valid_i = tbl[i].vld;
      for (int r = 0; r < N; r++) begin
        bus.req_a_i[r] = add_opnd_t'(tbl[i].a);
        bus.req_b_i[r] = add_opnd_t'(tbl[i].b);
      end
      bus.rsp_ready_i = tbl[i].rrdy;
      #1;
      chk($sformatf("vec%0d.ready", i), int'(bus.req_ready_o), tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.valid", i), int'(bus.rsp_valid_o), tbl[i].valid);
      chk($sformatf("vec%0d.sum", i),   int'(bus.rsp_sum_o),   tbl[i].sum);
      chk($sformatf("vec%0d.id", i),    int'(bus.rsp_id_o),    tbl[i].id);
`ifdef ADD10_ARB_COUT_EN
      chk($sformatf("vec%0d.cout", i),  dut_cout,              tbl[i].cout);
`endif
      @(negedge clk);
    end

    // Mid-burst reset: pending result vanishes at once, ptr back to 0.
    bus.req_valid_i = '1;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.pre_valid", int'(bus.rsp_valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid", int'(bus.rsp_valid_o), 0);
    chk("midrst.ready", int'(bus.req_ready_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.req_valid_i = 4'b0110;
    bus.req_a_i[1] = 10'h00F; bus.req_b_i[1] = 10'h001;
    bus.req_a_i[2] = 10'h020; bus.req_b_i[2] = 10'h002;
    step(g);
    chk("midrst.first_grant", g, 1);

    // Random traffic against the model.
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 99) < 45) begin
          pend[r] = 1'b1;
          ra[r] = ($urandom_range(0, 7) == 0) ? 10'h3FF : add_opnd_t'($urandom);
          rb[r] = add_opnd_t'($urandom);
        end
        bus.req_valid_i[r] = pend[r];
        bus.req_a_i[r] = ra[r];
        bus.req_b_i[r] = rb[r];
      end
      bus.rsp_ready_i = ($urandom_range(0, 99) < 70);
      step(g);
      if (g >= 0) pend[g] = 1'b0;
    end
    bus.req_valid_i = '0;
    #1;
    check_rsp("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add10_arbiter.md
# add10_arbiter

Round-robin arbiter that time-shares a single `adder_10bit` instance among `NUM_REQ` requesters (cache index/offset increment, LRU counter update, refill word address) in the pipelined RV32I cache subsystem. Each requester presents two 10-bit operands with a valid/ready handshake. One request is granted per cycle and its sum is captured in a one-entry output register. The result is returned with the winner's ID under a downstream valid/ready handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of requester ID (derived; do not override).
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `NUM_REQ`: per-requester operand valid.
- `req_ready_o` out `NUM_REQ`: per-requester grant/accept; one-hot or zero.
- `req_a_i` in `NUM_REQ`x10: operand A per requester.
- `req_b_i` in `NUM_REQ`x10: operand B per requester.
- `rsp_valid_o` out 1: result register holds a valid sum.
- `rsp_ready_i` in 1: downstream accepts result.
- `rsp_sum_o` out 10: (A+B) mod 1024.
- `rsp_id_o` out `ID_W`: index of the requester that produced the result.
- `rsp_cout_o` out 1: carry-out of bit 9. Present only with `ADD10_ARB_COUT_EN`.

## Operation
- Slot free: `slot_free = !rsp_valid_o || rsp_ready_i`.
- Winner: the first `i` with `req_valid_i[i]` set, scanning circularly from `ptr`.
- Grant: `req_ready_o[winner]=1` only when `slot_free`. All other ready bits are 0. Ready may depend combinationally on valid and `rsp_ready_i`.
- Transfer occurs on `req_valid_i[i] && req_ready_o[i]` at a rising edge. On transfer:
  - operands of the winner are muxed into `adder_10bit`;
  - the sum, the ID and (if enabled) the carry are registered;
  - `rsp_valid_o` is set to 1;
  - `ptr` becomes `winner+1`, wrapping `NUM_REQ-1`→0.
- Drain without refill (`rsp_valid_o && rsp_ready_i`, no transfer): `rsp_valid_o` becomes 0 at the next edge. Sum and ID hold their last values.
- Backpressure (`rsp_valid_o && !rsp_ready_i`): all `req_ready_o` are 0. Sum, ID and carry are held stable.
- Requesters hold valid and operands stable until their ready is seen. The arbiter does not check this.
- Fairness: a requester holding valid is granted within `NUM_REQ` transfers.
- `ptr` changes only on a transfer. Idle cycles do not rotate it.
- Arithmetic: unsigned, sum truncated to 10 bits. Overflow is not flagged unless `ADD10_ARB_COUT_EN` is defined.

## Timing
- Reset values (asynchronous, while `rst_ni`=0):
  - `rsp_valid_o`=0, `rsp_sum_o`=0, `rsp_id_o`=0, `rsp_cout_o`=0, `ptr`=0;
  - `req_ready_o` is forced to all-zero while in reset.
- Latency: a transfer at edge N gives `rsp_valid_o`=1 with the sum valid after edge N (1 cycle).
- Throughput: 1 result/cycle while `rsp_ready_i` is held 1. Drain and refill happen at the same edge.
- Reset mid-operation: a pending result is discarded and `ptr` returns to 0. The first cycle after deassertion, requester 0 has top priority.
- The adder path, including the winner mux, is combinational within one cycle. There is no internal pipelining.

## Configuration
- Macro: `ADD10_ARB_COUT_EN`.
- Defined: `rsp_cout_o` exists. It is registered alongside the sum as `(a[9]&b[9]) | ((a[9]^b[9]) & ~s[9])`, derived from the `adder_10bit` outputs, and is held under backpressure.
- Undefined: no port and no carry logic. Behaviour is otherwise identical.

## Structure
- Package `add10_arb_pkg` holds:
  - `ADD_W=10`;
  - `typedef logic [ADD_W-1:0] add_opnd_t`;
  - `MAX_REQ=8`.
- The existing `adder_10bit` is instantiated once as the shared datapath.
- One new sub-module, `add10_rr_pick`: a combinational circular priority picker. Inputs are `req` and `ptr`; outputs are a one-hot grant and the encoded index.

## Test plan
- Reset, then requester 2 only, A=0x123, B=0x0FF → ready[2]=1 in cycle 0; next cycle `rsp_valid_o`=1, sum=0x222, id=2.
- All 4 valid, `rsp_ready_i`=1 held → grant order 0,1,2,3,0 on consecutive cycles, one result/cycle.
- A=0x3FF, B=0x001 → sum=0x000. With `ADD10_ARB_COUT_EN`, `rsp_cout_o`=1.
- Result pending with `rsp_ready_i`=0 for 5 cycles, req 1 valid → `req_ready_o`=0 throughout, sum/id stable. `rsp_ready_i`→1 drains and grants req 1 at the same edge.
- Grant to 3, then reqs 0 and 3 valid → 0 wins (wrap). `rst_ni` pulsed low mid-burst → `rsp_valid_o`=0 immediately, next grant goes to the lowest valid index.
